// File: rtl/spw_pio_pkg.sv
// Shared definitions for the SpaceWire output PIO: register map, pulse FSM states, counter width.
package spw_pio_pkg;

    localparam int unsigned BUS_W       = 32;
    localparam int unsigned ADDR_W      = 2;
    localparam int unsigned PULSE_CNT_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_DATA  = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_PULSE = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_SET   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/spw_pio_pulse_gen.sv
// Self-clearing strobe engine: holds a mask high for PULSE_CYCLES clocks, restartable and OR-accumulating.
module spw_pio_pulse_gen
    import spw_pio_pkg::*;
#(
    parameter int unsigned WIDTH        = 6,
    parameter int unsigned PULSE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_pulse_mask,
    output logic             o_busy
);

    localparam logic [PULSE_CNT_W-1:0] RELOAD = PULSE_CNT_W'(PULSE_CYCLES - 1);

    pulse_state_t           r_state;
    pulse_state_t           w_state_nxt;
    logic [PULSE_CNT_W-1:0] r_cnt;
    logic [PULSE_CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]       r_mask;
    logic [WIDTH-1:0]       w_mask_nxt;
    logic                   w_start;

    assign w_start = i_load && (i_mask != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    // A nonzero load always wins, including over expiry in the final active cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = RELOAD;
                    w_mask_nxt  = i_mask;
                end
            end
            ACTIVE: begin
                if (w_start) begin
                    w_cnt_nxt  = RELOAD;
                    w_mask_nxt = r_mask | i_mask;
                end else if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_mask_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt - PULSE_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_mask_nxt  = '0;
            end
        endcase
    end

    assign o_pulse_mask = r_mask;
    assign o_busy       = (r_state == ACTIVE);

endmodule

// File: rtl/spw_pio_out.sv
// Avalon-MM output PIO driving SpaceWire core controls: data register, atomic set/clear, timed pulses.
module spw_pio_out
    import spw_pio_pkg::*;
#(
    parameter int unsigned     WIDTH        = 6,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned     PULSE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_wdata_unused;
    logic             w_pulse_load;
    logic [WIDTH-1:0] w_pulse_mask;
    logic             w_busy;
    logic [BUS_W-1:0] w_rdata;
    logic [WIDTH-1:0] r_data;
    logic [BUS_W-1:0] r_readdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_wdata_unused = ^writedata[BUS_W-1:WIDTH];
    assign w_pulse_load   = w_wr && (address == ADDR_PULSE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= RESET_VALUE;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:  r_data <= w_wdata;
                ADDR_SET:   r_data <= r_data | w_wdata;
                ADDR_CLEAR: r_data <= r_data & ~w_wdata;
                default:    r_data <= r_data;
            endcase
        end
    end

    spw_pio_pulse_gen #(
        .WIDTH        (WIDTH),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_pulse_gen (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_pulse_load),
        .i_mask       (w_wdata),
        .o_pulse_mask (w_pulse_mask),
        .o_busy       (w_busy)
    );

    // Read mux runs regardless of chipselect; SET/CLEAR are write-only.
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:  w_rdata = BUS_W'(r_data);
            ADDR_PULSE: w_rdata = BUS_W'(w_busy);
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_data | w_pulse_mask;

endmodule

// File: tb/tb_spw_pio_out.sv
// Directed self-checking bench for spw_pio_out (RESET_VALUE=6'h05, PULSE_CYCLES=16).
module tb_spw_pio_out;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [5:0]  out_port;

    int n_cmp;
    int n_err;

    spw_pio_out #(
        .WIDTH        (6),
        .RESET_VALUE  (6'h05),
        .PULSE_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits on a negedge; the write is sampled by the next posedge and the task returns on the following negedge.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        n_cmp++;
        if (out_port !== 6'h05) begin
            n_err++;
            $display("FAIL reset_out_port: got %h want 05", out_port);
        end
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_readdata: got %h want 0", readdata);
        end
        reset = 1'b0;
        @(negedge clk);
        bus_wr(2'd0, 32'h3F);
        bus_wr(2'd1, 32'h01);
        address = 2'd0;
        @(negedge clk);
        n_cmp++;
        if (out_port !== 6'h3F || readdata !== 32'h3F) begin
            n_err++;
            $display("FAIL pre_reset_state: out %h rd %h want 3f 3f", out_port, readdata);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (out_port !== 6'h05) begin
            n_err++;
            $display("FAIL async_reset_out_port: got %h want 05", out_port);
        end
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset_readdata: got %h want 0", readdata);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_rd(2'd1, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL reset_busy: got %h want 0", rd);
        end
        bus_rd(2'd0, rd);
        n_cmp++;
        if (rd !== 32'h5) begin
            n_err++;
            $display("FAIL reset_readback: got %h want 5", rd);
        end
    endtask

    task automatic test_data_set_clear();
        logic [31:0] rd;
        bus_wr(2'd0, 32'h2A);
        n_cmp++;
        if (out_port !== 6'h2A) begin
            n_err++;
            $display("FAIL data_write: got %h want 2a", out_port);
        end
        bus_wr(2'd2, 32'h01);
        n_cmp++;
        if (out_port !== 6'h2B) begin
            n_err++;
            $display("FAIL set: got %h want 2b", out_port);
        end
        bus_wr(2'd3, 32'h28);
        n_cmp++;
        if (out_port !== 6'h03) begin
            n_err++;
            $display("FAIL clear: got %h want 03", out_port);
        end
        bus_rd(2'd0, rd);
        n_cmp++;
        if (rd !== 32'h3) begin
            n_err++;
            $display("FAIL data_readback: got %h want 3", rd);
        end
        bus_rd(2'd2, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL set_read_zero: got %h want 0", rd);
        end
        bus_rd(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL clear_read_zero: got %h want 0", rd);
        end
        bus_wr(2'd0, 32'hFFFF_FFC0);
        n_cmp++;
        if (out_port !== 6'h00) begin
            n_err++;
            $display("FAIL high_bits_ignored: got %h want 00", out_port);
        end
        bus_rd(2'd0, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL high_bits_readback: got %h want 0", rd);
        end
    endtask

    task automatic test_pulse_timing();
        bus_wr(2'd1, 32'h10);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (out_port !== 6'h10) begin
                n_err++;
                $display("FAIL pulse_high cycle %0d: got %h want 10", i, out_port);
            end
            if (i == 8) begin
                n_cmp++;
                if (readdata !== 32'h1) begin
                    n_err++;
                    $display("FAIL pulse_busy: got %h want 1", readdata);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (out_port !== 6'h00) begin
            n_err++;
            $display("FAIL pulse_end: got %h want 00", out_port);
        end
        @(negedge clk);
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_err++;
            $display("FAIL pulse_idle: got %h want 0", readdata);
        end
    endtask

    task automatic test_restart();
        logic [31:0] rd;
        bus_wr(2'd1, 32'h10);
        repeat (15) @(negedge clk);
        n_cmp++;
        if (out_port !== 6'h10) begin
            n_err++;
            $display("FAIL restart_last_cycle: got %h want 10", out_port);
        end
        bus_wr(2'd1, 32'h01);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (out_port !== 6'h11) begin
                n_err++;
                $display("FAIL restart_high cycle %0d: got %h want 11", i, out_port);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (out_port !== 6'h00) begin
            n_err++;
            $display("FAIL restart_end: got %h want 00", out_port);
        end
        bus_wr(2'd1, 32'h0);
        n_cmp++;
        if (out_port !== 6'h00) begin
            n_err++;
            $display("FAIL zero_mask_idle: got %h want 00", out_port);
        end
        bus_rd(2'd1, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL zero_mask_busy: got %h want 0", rd);
        end
        // A zero-mask write in the expiry cycle must not extend the pulse.
        bus_wr(2'd1, 32'h02);
        repeat (15) @(negedge clk);
        bus_wr(2'd1, 32'h0);
        n_cmp++;
        if (out_port !== 6'h00) begin
            n_err++;
            $display("FAIL zero_mask_no_restart: got %h want 00", out_port);
        end
    endtask

    task automatic test_interaction();
        logic [31:0] rd;
        bus_wr(2'd0, 32'h04);
        bus_wr(2'd1, 32'h04);
        repeat (16) @(negedge clk);
        n_cmp++;
        if (out_port !== 6'h04) begin
            n_err++;
            $display("FAIL data_survives_pulse: got %h want 04", out_port);
        end
        bus_wr(2'd1, 32'h04);
        repeat (3) @(negedge clk);
        bus_wr(2'd3, 32'h04);
        n_cmp++;
        if (out_port !== 6'h04) begin
            n_err++;
            $display("FAIL clear_during_pulse: got %h want 04", out_port);
        end
        repeat (11) @(negedge clk);
        n_cmp++;
        if (out_port !== 6'h04) begin
            n_err++;
            $display("FAIL clear_pulse_last: got %h want 04", out_port);
        end
        @(negedge clk);
        n_cmp++;
        if (out_port !== 6'h00) begin
            n_err++;
            $display("FAIL clear_after_expiry: got %h want 00", out_port);
        end
        bus_rd(2'd0, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL clear_readback: got %h want 0", rd);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] rd;
        bus_wr(2'd1, 32'h08);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (out_port !== 6'h08) begin
            n_err++;
            $display("FAIL mid_pulse_pre: got %h want 08", out_port);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_port !== 6'h05) begin
            n_err++;
            $display("FAIL mid_pulse_reset: got %h want 05", out_port);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_port !== 6'h05) begin
                n_err++;
                $display("FAIL post_reset_quiet cycle %0d: got %h want 05", i, out_port);
            end
        end
        bus_rd(2'd1, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL post_reset_busy: got %h want 0", rd);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_data_set_clear();
        test_pulse_timing();
        test_restart();
        test_interaction();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spw_pio_out.md
Name: spw_pio_out

Overview:
- Avalon-MM write-capable output PIO slave. It drives a WIDTH-bit control bus, out_port, into the SpaceWire core, e.g. link enable, auto-start and credit-reset strobes.
- It is the counterpart of the read-only status-input PIO: software writes here, and the core's status comes back through the input PIO.
- Provides a plain data register, atomic bit set/clear, and self-clearing timed pulses.

Parameters:
- WIDTH, 6, width of out_port and of the active register bits.
- RESET_VALUE, 0, value of the DATA register after reset.
- PULSE_CYCLES, 16, number of clk cycles a PULSE bit stays high. Legal range is 1 to 65535.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  Avalon word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, valid only with chipselect.
- writedata  input  32  write data; only bits [WIDTH-1:0] are used.
- readdata  output  32  registered read data, zero-extended.
- out_port  output  WIDTH  control bus to the core; equals data_reg OR pulse_mask.

Behaviour:
- wr = chipselect & ~write_n. No waitrequest; every write completes in one cycle.
- Register map:
  - 0 DATA (read/write): a write loads data_reg with writedata[WIDTH-1:0].
  - 1 PULSE: a write starts a pulse. A read returns {31'b0, busy}.
  - 2 SET (write-only): data_reg <= data_reg | wdata. Reads return 0.
  - 3 CLEAR (write-only): data_reg <= data_reg & ~wdata. Reads return 0.
- Reset (asynchronous, immediate):
  - data_reg = RESET_VALUE, pulse_mask = 0, busy = 0, counter = 0, readdata = 0.
  - out_port therefore equals RESET_VALUE during and after reset.
- Reset asserted mid-pulse aborts the pulse at once; no residual strobe after release.
- Read path: readdata is updated every cycle from the address mux, with chipselect not required. Read latency is 1 cycle. Unused high bits are 0.
- Write effect: out_port reflects a write from the rising edge that samples wr, i.e. the next cycle. No combinational path from bus inputs to out_port.
- Pulse engine states:
  - IDLE (busy=0): on a PULSE write with nonzero mask, go to ACTIVE with pulse_mask <= wdata and counter <= PULSE_CYCLES-1.
  - ACTIVE (busy=1): counter decrements each cycle. When counter==0 and there is no PULSE write, pulse_mask <= 0, busy <= 0, return to IDLE.
  - Mask bits are therefore high for exactly PULSE_CYCLES cycles.
- PULSE write while ACTIVE, including the expiry cycle: pulse_mask <= pulse_mask | wdata and counter is reloaded. Restart wins over expiry.
- PULSE write with zero mask has no effect in either state, and no restart.
- Pulse and DATA bits are independent. A bit set in DATA stays high after its pulse ends. A CLEAR does not cut an active pulse.
- Counter width is 16 bits. It never wraps, because decrement stops at 0.
- A write to address 1 does not modify data_reg.

Decomposition:
- Shared package spw_pio_pkg:
  - address constants ADDR_DATA=0, ADDR_PULSE=1, ADDR_SET=2, ADDR_CLEAR=3;
  - pulse state enum {IDLE, ACTIVE};
  - PULSE_CNT_W=16.
- One sub-module: spw_pio_pulse_gen. It holds the pulse FSM, counter and mask, taking load/mask inputs and giving pulse_mask/busy outputs.
- The top level keeps the register file, address decode and read mux.

Test Plan:
- Reset: with RESET_VALUE=6'h05, assert reset mid-cycle -> out_port=6'h05 immediately, readdata=0, busy=0. Release, then read addr 0 -> 0x00000005 one cycle later.
- DATA and SET/CLEAR:
  - write 0x2A to addr 0 -> out_port=6'h2A next cycle;
  - SET 0x01 -> 6'h2B;
  - CLEAR 0x28 -> 6'h03;
  - writedata 0xFFFFFFC0 to addr 0 -> out_port=0, readback 0.
- Pulse timing: PULSE_CYCLES=16, write 0x10 to addr 1 -> out_port[4] high for exactly 16 cycles. Read addr 1 gives 1 during the pulse and 0 afterwards.
- Pulse restart at expiry: write 0x01 to addr 1 in the last ACTIVE cycle -> mask=0x11 and 16 more cycles, then both bits drop together. A zero-mask PULSE write has no effect.
- Interaction:
  - DATA=0x04 plus pulse 0x04 -> bit 2 stays high after expiry;
  - CLEAR 0x04 during the pulse -> bit 2 stays high until expiry, then low.
- Reset mid-pulse: assert reset 5 cycles into a pulse -> out_port=RESET_VALUE at once, busy=0. After release out_port stays RESET_VALUE with no spurious pulse.
